apb_event_arbiter: RTL
======================

APB_EVENT_ARBITER -- requirements
Module: apb_event_arbiter

Interface
REQ-001 Parameters SHALL be N_REQ (default 3, number of requesters), ADDR_W (default 32, APB address width), DATA_W (default 32, APB data width) and TIMEOUT (default 16, maximum ACCESS cycles waiting for pready).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req_i, input, N_REQ bits: per-requester write request level.
REQ-005 Port req_addr_i, input, N_REQ*ADDR_W bits: per-requester target address, requester k at slice [k*ADDR_W +: ADDR_W].
REQ-006 Port req_wdata_i, input, N_REQ*DATA_W bits: per-requester write data, sliced the same way as req_addr_i.
REQ-007 Port done_o, output, N_REQ bits: one-cycle completion pulse to the served requester.
REQ-008 Port err_o, output, 1 bit: valid with done_o; high on pslverr or timeout.
REQ-009 Ports apb_psel_o (1 bit), apb_penable_o (1 bit), apb_paddr_o (ADDR_W bits), apb_pwrite_o (1 bit) and apb_pwdata_o (DATA_W bits): outputs forming the APB master request.
REQ-010 Ports apb_pready_i (1 bit) and apb_pslverr_i (1 bit): inputs forming the APB completer response.

Function
REQ-011 Every output SHALL be registered; no combinational path from input to output.
REQ-012 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE.
REQ-013 IDLE: on any req_i bit high, the block SHALL grant round-robin, starting at the index after the last served requester (index 0 first after reset), latch that requester's addr and wdata, and enter SETUP.
REQ-014 SETUP: psel=1, penable=0, paddr/pwdata = latched values, pwrite=1; the FSM SHALL go to ACCESS after exactly one cycle.
REQ-015 ACCESS: psel=1, penable=1; the FSM SHALL stay until apb_pready_i=1 is sampled or the wait counter reaches TIMEOUT.
REQ-016 The paddr/pwdata/pwrite values SHALL stay stable from SETUP through the end of ACCESS.
REQ-017 On pready: the FSM SHALL enter DONE with psel=penable=0, done_o[grant]=1 for one cycle and err_o=apb_pslverr_i as sampled with pready.
REQ-018 On timeout (TIMEOUT ACCESS cycles without pready): the FSM SHALL abort to DONE with psel=penable=0, done_o[grant]=1 and err_o=1.
REQ-019 DONE SHALL last one cycle and then go to IDLE, giving a minimum 1-cycle bus-idle gap between transfers.
REQ-020 Best-case latency from req_i high (in IDLE) to done_o pulse SHALL be 3 clk edges with pready held high.
REQ-021 The round-robin pointer SHALL update to grant+1 (mod N_REQ) at DONE, for both success and timeout.
REQ-022 With simultaneous requests, the first set bit at or after the pointer, with wrap-around, SHALL win.
REQ-023 req_i deasserted after grant SHALL be ignored; the transfer completes and done_o still pulses.
REQ-024 A requester still high after its done_o SHALL be treated as a new request.
REQ-025 A pready that is high in SETUP, or in IDLE/DONE, SHALL be ignored.
REQ-026 The ACCESS wait counter SHALL be $clog2(TIMEOUT+1) bits, SHALL clear on SETUP entry and SHALL saturate.

Reset
REQ-027 reset low SHALL immediately force FSM=IDLE, pointer=0, counter=0 and all outputs to 0, including mid-transfer, with no done_o for the aborted transfer.
REQ-028 Release of reset SHALL take effect on the next rising clk edge; requests present at that edge SHALL be arbitrated normally.

Structure
REQ-029 The FSM state encoding and the default timeout constant SHALL live in the shared package apb_events_pkg.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: req vector and pointer; outputs: one-hot grant, index, any-valid), purely combinational.

Verification
REQ-031 Single request: req_i=3'b001, addr 0x10, wdata 0xA5, pready high in ACCESS -> psel rises at edge 1, penable at edge 2, done_o=3'b001 at edge 3 with err_o=0.
REQ-032 All requests held: req_i=3'b111 -> serve order 0,1,2,0, each paddr matching its requester.
REQ-033 Wait states: pready low for 4 ACCESS cycles, then high -> penable high for 5 cycles, paddr/pwdata stable throughout, a single done pulse.
REQ-034 Timeout: pready never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, then done_o pulse with err_o=1, and the next requester is served.
REQ-035 pslverr: pready=1 with pslverr=1 -> done_o with err_o=1; the pointer advances.
REQ-036 Reset in ACCESS: reset low -> psel, penable and done_o are 0 before the next clock edge; after release, req_i=3'b010 is served first (pointer=0 scan).

Source files
------------

// File: rtl/apb_events_pkg.sv
// Shared types and constants for the APB event arbiter slice.
// Holds the FSM encoding, the default timeout and an index-width helper.
package apb_events_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping around, wins.
module rr_arbiter
    import apb_events_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int k;
        logic [IDX_W-1:0] kk;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            kk = IDX_W'(k);
            if (!valid && req[kk]) begin
                valid     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/apb_event_arbiter.sv
// Arbitrates N_REQ write requesters onto a single APB master port, one
// transfer at a time, with round-robin fairness and an ACCESS-phase timeout.
module apb_event_arbiter
    import apb_events_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]        done_o,
    output logic                    err_o,
    output logic                    apb_psel_o,
    output logic                    apb_penable_o,
    output logic [ADDR_W-1:0]       apb_paddr_o,
    output logic                    apb_pwrite_o,
    output logic [DATA_W-1:0]       apb_pwdata_o,
    input  logic                    apb_pready_i,
    input  logic                    apb_pslverr_i
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic [CNT_W-1:0] wait_cnt;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [IDX_W-1:0] next_ptr;
    logic             wait_expired;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_rr_arbiter (
        .req  (req_i),
        .ptr  (rr_ptr),
        .grant(arb_grant),
        .idx  (arb_idx),
        .valid(arb_valid)
    );

    assign next_ptr     = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    // The cycle that would bring the count to TIMEOUT is the last one allowed.
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            grant_oh      <= '0;
            wait_cnt      <= '0;
            done_o        <= '0;
            err_o         <= 1'b0;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwrite_o  <= 1'b0;
            apb_pwdata_o  <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_idx     <= arb_idx;
                        grant_oh      <= arb_grant;
                        apb_paddr_o   <= addr_arr[arb_idx];
                        apb_pwdata_o  <= wdata_arr[arb_idx];
                        apb_pwrite_o  <= 1'b1;
                        apb_psel_o    <= 1'b1;
                        apb_penable_o <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_penable_o <= 1'b1;
                    state         <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!apb_pready_i && wait_cnt != CNT_W'(TIMEOUT))
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    if (apb_pready_i || wait_expired) begin
                        apb_psel_o    <= 1'b0;
                        apb_penable_o <= 1'b0;
                        apb_pwrite_o  <= 1'b0;
                        done_o        <= grant_oh;
                        err_o         <= apb_pready_i ? apb_pslverr_i : 1'b1;
                        rr_ptr        <= next_ptr;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
